// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter with burst lock for a shared single-port memory.
// Requester 0 (c_*) is the CPU control unit, requester 1 (d_*) the loader/DMA engine.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic                  c_lock,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  output logic [DATA_WIDTH-1:0] c_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic                  d_lock,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED_C = 2'd1,
    ST_LOCKED_D = 2'd2
  } lock_state_t;

  lock_state_t           r_state;
  lock_state_t           w_next_state;
  logic                  r_last_d;
  logic                  r_c_gnt;
  logic                  r_d_gnt;
  logic                  r_c_rvalid;
  logic                  r_d_rvalid;
  logic                  r_mem_rw;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  w_c_elig;
  logic                  w_d_elig;
  logic                  w_c_win;
  logic                  w_d_win;

  // A requester whose grant is showing is still holding the same request, so it sits out.
  always_comb begin
    w_c_elig = c_req & ~r_c_gnt & ~((r_state == ST_LOCKED_D) & d_lock);
    w_d_elig = d_req & ~r_d_gnt & ~((r_state == ST_LOCKED_C) & c_lock);
    w_c_win  = w_c_elig & (~w_d_elig | r_last_d);
    w_d_win  = w_d_elig & ~w_c_win;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_c_win && c_lock) begin
      w_next_state = ST_LOCKED_C;
    end else if (w_d_win && d_lock) begin
      w_next_state = ST_LOCKED_D;
    end else if ((r_state == ST_LOCKED_C) && !c_lock) begin
      w_next_state = ST_UNLOCKED;
    end else if ((r_state == ST_LOCKED_D) && !d_lock) begin
      w_next_state = ST_UNLOCKED;
    end
  end

  // Pointer resets to "d granted last" so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_UNLOCKED;
      r_last_d   <= 1'b1;
      r_c_gnt    <= 1'b0;
      r_d_gnt    <= 1'b0;
      r_c_rvalid <= 1'b0;
      r_d_rvalid <= 1'b0;
      r_mem_rw   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      r_state    <= w_next_state;
      r_c_gnt    <= w_c_win;
      r_d_gnt    <= w_d_win;
      r_c_rvalid <= r_c_gnt & ~r_mem_rw;
      r_d_rvalid <= r_d_gnt & ~r_mem_rw;
      if (w_c_win) begin
        r_mem_rw   <= c_we;
        r_mem_addr <= c_addr;
        r_mem_data <= c_wdata;
        r_last_d   <= 1'b0;
      end else if (w_d_win) begin
        r_mem_rw   <= d_we;
        r_mem_addr <= d_addr;
        r_mem_data <= d_wdata;
        r_last_d   <= 1'b1;
      end else begin
        r_mem_rw   <= 1'b0;
      end
    end
  end

  assign c_gnt    = r_c_gnt;
  assign d_gnt    = r_d_gnt;
  assign c_rvalid = r_c_rvalid;
  assign d_rvalid = r_d_rvalid;
  assign c_rdata  = mem_q;
  assign d_rdata  = mem_q;
  assign mem_rw   = r_mem_rw;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, then random traffic against a reference model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_gnt, c_rvalid, d_gnt, d_rvalid, mem_rw;
  logic [7:0]  c_rdata, d_rdata, mem_data, mem_q;
  logic [15:0] mem_addr;

  bit          req [2];
  bit          we  [2];
  bit          lk  [2];
  logic [15:0] ad  [2];
  logic [7:0]  wd  [2];

  logic [7:0]  mem  [0:65535];
  logic [7:0]  mmem [0:65535];

  bit          m_gnt [2];
  bit          m_rv  [2];
  bit          m_rw;
  logic [15:0] m_addr;
  logic [7:0]  m_data;
  logic [7:0]  m_rdata [2];
  int          owner;
  int          last;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit rst;
    bit cr, cw, cl; logic [15:0] ca; logic [7:0] cd;
    bit dr, dw, dl; logic [15:0] da; logic [7:0] dd;
    bit ecg, edg, ecrv, edrv, erw;
    logic [15:0] eaddr; logic [7:0] edata, erdc, erdd;
  } vec_t;

  vec_t tbl [$];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .c_req(req[0]), .c_we(we[0]), .c_lock(lk[0]), .c_addr(ad[0]), .c_wdata(wd[0]),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .d_req(req[1]), .d_we(we[1]), .d_lock(lk[1]), .d_addr(ad[1]), .d_wdata(wd[1]),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q)
  );

  // Synchronous memory: data appears one edge after the address is sampled.
  always @(posedge clk) begin
    if (mem_rw === 1'b1) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) ^ (a >> 8));
  endfunction

  function automatic vec_t v(
    input bit r,
    input bit cr, input bit cw, input bit cl, input logic [15:0] ca, input logic [7:0] cd,
    input bit dr, input bit dw, input bit dl, input logic [15:0] da, input logic [7:0] dd,
    input bit ecg, input bit edg, input bit ecrv, input bit edrv, input bit erw,
    input logic [15:0] eaddr, input logic [7:0] edata, input logic [7:0] erdc,
    input logic [7:0] erdd);
    vec_t t;
    t.rst = r;
    t.cr = cr; t.cw = cw; t.cl = cl; t.ca = ca; t.cd = cd;
    t.dr = dr; t.dw = dw; t.dl = dl; t.da = da; t.dd = dd;
    t.ecg = ecg; t.edg = edg; t.ecrv = ecrv; t.edrv = edrv; t.erw = erw;
    t.eaddr = eaddr; t.edata = edata; t.erdc = erdc; t.erdd = erdd;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: one call per clock edge, from the rules of the arbiter.
  task automatic model_step(input bit r);
    bit el [2];
    bit nrv [2];
    int win;
    if (m_gnt[0] || m_gnt[1]) begin
      if (m_rw) mmem[m_addr] = m_data;
      else for (int i = 0; i < 2; i++) if (m_gnt[i]) m_rdata[i] = mmem[m_addr];
    end
    if (r) begin
      for (int i = 0; i < 2; i++) begin m_gnt[i] = 0; m_rv[i] = 0; end
      m_rw = 0; m_addr = '0; m_data = '0; owner = -1; last = 1;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      nrv[i] = m_gnt[i] && !m_rw;
      el[i]  = req[i] && !m_gnt[i] && !(owner == 1 - i && lk[1 - i]);
    end
    if (owner >= 0 && !lk[owner]) owner = -1;
    if (el[0] && el[1]) win = 1 - last;
    else if (el[0]) win = 0;
    else if (el[1]) win = 1;
    else win = -1;
    for (int i = 0; i < 2; i++) begin m_gnt[i] = (win == i); m_rv[i] = nrv[i]; end
    if (win >= 0) begin
      m_rw = we[win]; m_addr = ad[win]; m_data = wd[win]; last = win;
      if (lk[win]) owner = win;
    end else begin
      m_rw = 0;
    end
  endtask

  task automatic cycle(input bit r);
    rst = r;
    @(posedge clk);
    model_step(r);
    #1;
    chk("model c_gnt", 32'(c_gnt), 32'(m_gnt[0]));
    chk("model d_gnt", 32'(d_gnt), 32'(m_gnt[1]));
    chk("model c_rvalid", 32'(c_rvalid), 32'(m_rv[0]));
    chk("model d_rvalid", 32'(d_rvalid), 32'(m_rv[1]));
    chk("model mem_rw", 32'(mem_rw), 32'(m_rw));
    chk("model mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("model mem_data", 32'(mem_data), 32'(m_data));
    if (m_rv[0]) chk("model c_rdata", 32'(c_rdata), 32'(m_rdata[0]));
    if (m_rv[1]) chk("model d_rdata", 32'(d_rdata), 32'(m_rdata[1]));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] <= pat(i);
      mmem[i] = pat(i);
    end
    mem[16'h0010] <= 8'hA5;
    mmem[16'h0010] = 8'hA5;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; lk[i] = 0; ad[i] = '0; wd[i] = '0;
      m_gnt[i] = 0; m_rv[i] = 0; m_rdata[i] = '0;
    end
    m_rw = 0; m_addr = '0; m_data = '0; owner = -1; last = 1;
    rst = 1'b1;

    // reset, single read
    tbl.push_back(v(1, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,0,0,0,16'h0,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h10,8'h0, 0,0,0,16'h0,8'h0, 1,0,0,0,0,16'h10,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 0,0,0,16'h10,8'h0, 0,0,0,16'h0,8'h0, 0,0,1,0,0,16'h10,8'h0,8'hA5,8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,0,0,0,16'h10,8'h0,8'h0,8'h0));
    // write then read back
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 1,1,0,16'h20,8'h3C, 0,1,0,0,1,16'h20,8'h3C,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h20,8'h0, 0,0,0,16'h0,8'h0, 1,0,0,0,0,16'h20,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,1,0,0,16'h20,8'h0,8'h3C,8'h0));
    // contention from reset: c,d,c,d
    tbl.push_back(v(1, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,0,0,0,16'h0,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h40,8'h0, 1,0,0,16'h50,8'h0, 1,0,0,0,0,16'h40,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h41,8'h0, 1,0,0,16'h50,8'h0,
                    0,1,1,0,0,16'h50,8'h0,pat(16'h40),8'h0));
    tbl.push_back(v(0, 1,0,0,16'h41,8'h0, 1,0,0,16'h51,8'h0,
                    1,0,0,1,0,16'h41,8'h0,8'h0,pat(16'h50)));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 1,0,0,16'h51,8'h0,
                    0,1,1,0,0,16'h51,8'h0,pat(16'h41),8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0,
                    0,0,0,1,0,16'h51,8'h0,8'h0,pat(16'h51)));
    // locked burst by d while c waits
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 1,1,1,16'h30,8'h11, 0,1,0,0,1,16'h30,8'h11,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h60,8'h0, 1,1,1,16'h31,8'h22, 0,0,0,0,0,16'h30,8'h11,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h60,8'h0, 1,1,1,16'h31,8'h22, 0,1,0,0,1,16'h31,8'h22,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h60,8'h0, 1,1,1,16'h32,8'h33, 0,0,0,0,0,16'h31,8'h22,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h60,8'h0, 1,1,1,16'h32,8'h33, 0,1,0,0,1,16'h32,8'h33,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h60,8'h0, 0,0,0,16'h0,8'h0, 1,0,0,0,0,16'h60,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0,
                    0,0,1,0,0,16'h60,8'h0,pat(16'h60),8'h0));
    // lone requester: grant every other cycle
    for (int k = 0; k < 6; k++)
      tbl.push_back(v(0, 1,0,0,16'h70,8'h0, 0,0,0,16'h0,8'h0,
                      (k % 2) == 0, 0, (k % 2) == 1, 0, 0, 16'h70, 8'h0, pat(16'h70), 8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,0,0,0,16'h70,8'h0,8'h0,8'h0));
    // reset in the grant cycle of a read
    tbl.push_back(v(0, 1,0,0,16'h80,8'h0, 0,0,0,16'h0,8'h0, 1,0,0,0,0,16'h80,8'h0,8'h0,8'h0));
    tbl.push_back(v(1, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0, 0,0,0,0,0,16'h0,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 1,0,0,16'h90,8'h0, 1,0,0,16'hA0,8'h0, 1,0,0,0,0,16'h90,8'h0,8'h0,8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 1,0,0,16'hA0,8'h0,
                    0,1,1,0,0,16'hA0,8'h0,pat(16'h90),8'h0));
    tbl.push_back(v(0, 0,0,0,16'h0,8'h0, 0,0,0,16'h0,8'h0,
                    0,0,0,1,0,16'hA0,8'h0,8'h0,pat(16'hA0)));

    foreach (tbl[k]) begin
      req[0] = tbl[k].cr; we[0] = tbl[k].cw; lk[0] = tbl[k].cl;
      ad[0] = tbl[k].ca; wd[0] = tbl[k].cd;
      req[1] = tbl[k].dr; we[1] = tbl[k].dw; lk[1] = tbl[k].dl;
      ad[1] = tbl[k].da; wd[1] = tbl[k].dd;
      cycle(tbl[k].rst);
      chk($sformatf("vec%0d c_gnt", k), 32'(c_gnt), 32'(tbl[k].ecg));
      chk($sformatf("vec%0d d_gnt", k), 32'(d_gnt), 32'(tbl[k].edg));
      chk($sformatf("vec%0d c_rvalid", k), 32'(c_rvalid), 32'(tbl[k].ecrv));
      chk($sformatf("vec%0d d_rvalid", k), 32'(d_rvalid), 32'(tbl[k].edrv));
      chk($sformatf("vec%0d mem_rw", k), 32'(mem_rw), 32'(tbl[k].erw));
      chk($sformatf("vec%0d mem_addr", k), 32'(mem_addr), 32'(tbl[k].eaddr));
      chk($sformatf("vec%0d mem_data", k), 32'(mem_data), 32'(tbl[k].edata));
      if (tbl[k].ecrv) chk($sformatf("vec%0d c_rdata", k), 32'(c_rdata), 32'(tbl[k].erdc));
      if (tbl[k].edrv) chk($sformatf("vec%0d d_rdata", k), 32'(d_rdata), 32'(tbl[k].erdd));
    end

    // random traffic; requesters hold their request until granted
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) == 0);
      for (int i = 0; i < 2; i++) begin
        if (m_gnt[i] || !req[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[i] = 1;
            we[i]  = 1'($urandom_range(0, 1));
            ad[i]  = 16'($urandom_range(0, 15));
            wd[i]  = 8'($urandom);
            lk[i]  = ($urandom_range(0, 3) == 0);
          end else begin
            req[i] = 0;
            lk[i]  = ($urandom_range(0, 3) == 0);
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
